// File: rtl/sdram_arbiter.sv
// Two-port (CPU / DMA) arbiter sharing the SDRAM controller request port, with a turnaround gap between owners.
// Optional stall watchdog, TIMEOUT pulse and re-grant block flags are built when ARB_TIMEOUT_EN is defined.
module sdram_arbiter #(
  parameter int unsigned TURN_GAP = 2,
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_ACCESS,
  input  logic        CPU_RW,
  input  logic        CPU_UDS,
  input  logic        CPU_LDS,
  input  logic [23:1] CPU_A,
  output logic        CPU_VALID,
  output logic        CPU_WTERM,
  input  logic        DMA_ACCESS,
  input  logic        DMA_RW,
  input  logic        DMA_UDS,
  input  logic        DMA_LDS,
  input  logic [23:1] DMA_A,
  output logic        DMA_VALID,
  output logic        DMA_WTERM,
  output logic        ACCESS,
  output logic        RW,
  output logic        UDS,
  output logic        LDS,
  output logic [23:1] A,
  input  logic        VALID,
  input  logic        WTERM,
  output logic [1:0]  GRANT,
  output logic        TIMEOUT
);

  if (TURN_GAP < 1 || TURN_GAP > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
    $error("sdram_arbiter: TURN_GAP must be 1..15 and MAX_HOLD 1..255");
  end

  typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(TURN_GAP - 1);

  state_t     state;
  logic       last_dma;   // 1 when the DMA owned the port most recently
  logic [3:0] gap_cnt;
  logic       owner_acc;
  logic       cpu_req;
  logic       dma_req;

  assign owner_acc = (state == CPU_OWN) ? CPU_ACCESS : DMA_ACCESS;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic       blk_cpu;
  logic       blk_dma;

  // A requester that timed out stays ineligible until it lets go once.
  assign cpu_req = !CPU_ACCESS && !blk_cpu;
  assign dma_req = !DMA_ACCESS && !blk_dma;
`else
  assign cpu_req = !CPU_ACCESS;
  assign dma_req = !DMA_ACCESS;
  assign TIMEOUT = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      GRANT    <= 2'b00;
      last_dma <= 1'b1;
      gap_cnt  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      blk_cpu  <= 1'b0;
      blk_dma  <= 1'b0;
      TIMEOUT  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      TIMEOUT <= 1'b0;
      if (CPU_ACCESS) blk_cpu <= 1'b0;
      if (DMA_ACCESS) blk_dma <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
          if (cpu_req && (!dma_req || last_dma)) begin
            state <= CPU_OWN;
            GRANT <= 2'b01;
          end else if (dma_req) begin
            state <= DMA_OWN;
            GRANT <= 2'b10;
          end
        end
        CPU_OWN, DMA_OWN: begin
          if (owner_acc) begin
            state    <= GAP;
            GRANT    <= 2'b00;
            gap_cnt  <= GAP_LOAD;
            last_dma <= (state == DMA_OWN);
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_MAX) begin
            state    <= GAP;
            GRANT    <= 2'b00;
            gap_cnt  <= GAP_LOAD;
            last_dma <= (state == DMA_OWN);
            TIMEOUT  <= 1'b1;
            if (state == CPU_OWN) blk_cpu <= 1'b1;
            else                  blk_dma <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 4'd1;
        end
      endcase
    end
  end

  // Request path muxed by registered state so the controller sees it settled by its negedge sample.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ACCESS    = 1'b1;
    RW        = 1'b1;
    UDS       = 1'b1;
    LDS       = 1'b1;
    A         = '0;
    CPU_VALID = 1'b1;
    CPU_WTERM = 1'b1;
    DMA_VALID = 1'b1;
    DMA_WTERM = 1'b1;
    case (state)
      CPU_OWN: begin
        ACCESS    = CPU_ACCESS;
        RW        = CPU_RW;
        UDS       = CPU_UDS;
        LDS       = CPU_LDS;
        A         = CPU_A;
        CPU_VALID = VALID;
        CPU_WTERM = WTERM;
      end
      DMA_OWN: begin
        ACCESS    = DMA_ACCESS;
        RW        = DMA_RW;
        UDS       = DMA_UDS;
        LDS       = DMA_LDS;
        A         = DMA_A;
        DMA_VALID = VALID;
        DMA_WTERM = WTERM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: an ownership/timeline model pushes expected outputs each cycle,
// a negedge monitor pops and compares. Directed scenarios are followed by randomized requester traffic.
module tb_sdram_arbiter;
  localparam int TURN_GAP = 2;
  localparam int MAX_HOLD = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CPU_ACCESS, CPU_RW, CPU_UDS, CPU_LDS;
  logic [23:1] CPU_A;
  logic        CPU_VALID, CPU_WTERM;
  logic        DMA_ACCESS, DMA_RW, DMA_UDS, DMA_LDS;
  logic [23:1] DMA_A;
  logic        DMA_VALID, DMA_WTERM;
  logic        ACCESS, RW, UDS, LDS;
  logic [23:1] A;
  logic        VALID, WTERM;
  logic [1:0]  GRANT;
  logic        TIMEOUT;

  always #5 CLK = ~CLK;

  sdram_arbiter #(.TURN_GAP(TURN_GAP), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_ACCESS(CPU_ACCESS), .CPU_RW(CPU_RW), .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS), .CPU_A(CPU_A),
    .CPU_VALID(CPU_VALID), .CPU_WTERM(CPU_WTERM),
    .DMA_ACCESS(DMA_ACCESS), .DMA_RW(DMA_RW), .DMA_UDS(DMA_UDS), .DMA_LDS(DMA_LDS), .DMA_A(DMA_A),
    .DMA_VALID(DMA_VALID), .DMA_WTERM(DMA_WTERM),
    .ACCESS(ACCESS), .RW(RW), .UDS(UDS), .LDS(LDS), .A(A),
    .VALID(VALID), .WTERM(WTERM), .GRANT(GRANT), .TIMEOUT(TIMEOUT)
  );

  typedef struct packed {
    logic [1:0]  grant;
    logic        timeout;
    logic        access, rw, uds, lds;
    logic [22:0] a;
    logic        cv, cw, dv, dw;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: who owns the port, from which edge, and the first edge a new grant is allowed.
  int owner = 0;        // 0 none, 1 CPU, 2 DMA
  int last = 2;
  int t = 0;
  int free_at = 0;
  int own_start = 0;
  bit blk [1:2];
  bit to_pulse = 1'b0;

  // Pending stimulus, applied just after the next posedge.
  logic        p_rst;
  logic        p_acc [1:2];
  logic        p_rw  [1:2];
  logic        p_uds [1:2];
  logic        p_lds [1:2];
  logic [23:1] p_a   [1:2];
  logic        p_valid, p_wterm;

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got grant=%b to=%b acc/rw/uds/lds=%b%b%b%b a=%h cv/cw/dv/dw=%b%b%b%b, required grant=%b to=%b acc/rw/uds/lds=%b%b%b%b a=%h cv/cw/dv/dw=%b%b%b%b",
               name, $time, got.grant, got.timeout, got.access, got.rw, got.uds, got.lds, got.a,
               got.cv, got.cw, got.dv, got.dw, exp.grant, exp.timeout, exp.access, exp.rw, exp.uds,
               exp.lds, exp.a, exp.cv, exp.cw, exp.dv, exp.dw);
    end
  endtask

  task automatic model_reset();
    owner    = 0;
    last     = 2;
    blk[1]   = 1'b0;
    blk[2]   = 1'b0;
    to_pulse = 1'b0;
    free_at  = t;
  endtask

  task automatic model_edge();
    bit acc [1:2];
    bit c, d;
    acc[1]   = CPU_ACCESS;
    acc[2]   = DMA_ACCESS;
    to_pulse = 1'b0;
    if (owner != 0) begin
      if (acc[owner]) begin
        last    = owner;
        owner   = 0;
        free_at = t + TURN_GAP + 1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (t - own_start == MAX_HOLD + 1) begin
        blk[owner] = 1'b1;
        last       = owner;
        owner      = 0;
        free_at    = t + TURN_GAP + 1;
        to_pulse   = 1'b1;
      end
`endif
    end else if (t >= free_at) begin
      c = !acc[1] && !blk[1];
      d = !acc[2] && !blk[2];
      if (c && (!d || last == 2)) begin
        owner = 1;
        own_start = t;
      end else if (d) begin
        owner = 2;
        own_start = t;
      end
    end
    if (acc[1]) blk[1] = 1'b0;
    if (acc[2]) blk[2] = 1'b0;
    t++;
  endtask

  function automatic obs_t expect_now();
    obs_t e;
    e = '{grant: 2'b00, timeout: to_pulse, access: 1'b1, rw: 1'b1, uds: 1'b1, lds: 1'b1,
          a: 23'h0, cv: 1'b1, cw: 1'b1, dv: 1'b1, dw: 1'b1};
    if (owner == 1) begin
      e.grant = 2'b01; e.access = CPU_ACCESS; e.rw = CPU_RW; e.uds = CPU_UDS; e.lds = CPU_LDS;
      e.a = CPU_A; e.cv = VALID; e.cw = WTERM;
    end else if (owner == 2) begin
      e.grant = 2'b10; e.access = DMA_ACCESS; e.rw = DMA_RW; e.uds = DMA_UDS; e.lds = DMA_LDS;
      e.a = DMA_A; e.dv = VALID; e.dw = WTERM;
    end
    return e;
  endfunction

  task automatic apply();
    RST        = p_rst;
    CPU_ACCESS = p_acc[1]; CPU_RW = p_rw[1]; CPU_UDS = p_uds[1]; CPU_LDS = p_lds[1]; CPU_A = p_a[1];
    DMA_ACCESS = p_acc[2]; DMA_RW = p_rw[2]; DMA_UDS = p_uds[2]; DMA_LDS = p_lds[2]; DMA_A = p_a[2];
    VALID      = p_valid;
    WTERM      = p_wterm;
    if (p_rst) model_reset();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (!RST) model_edge();
      else t++;
      #1;
      apply();
      sb.push_back(expect_now());
    end
  endtask

  task automatic rand_fields(input int x);
    p_rw[x]  = 1'($urandom_range(1));
    p_uds[x] = 1'($urandom_range(1));
    p_lds[x] = 1'($urandom_range(1));
    p_a[x]   = 23'($urandom);
  endtask

  always @(negedge CLK) begin
    obs_t e, g;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      g = {GRANT, TIMEOUT, ACCESS, RW, UDS, LDS, A, CPU_VALID, CPU_WTERM, DMA_VALID, DMA_WTERM};
      check("outputs", g, e);
    end
  end

  bit act [1:2];
  int hold_len [1:2];

  initial begin
    p_rst = 1'b1; p_valid = 1'b1; p_wterm = 1'b1;
    for (int x = 1; x <= 2; x++) begin
      p_acc[x] = 1'b1; p_rw[x] = 1'b1; p_uds[x] = 1'b1; p_lds[x] = 1'b1; p_a[x] = '0;
      act[x] = 1'b0; hold_len[x] = 0;
    end
    apply();
    step(3);
    p_rst = 1'b0;
    step(2);

    // CPU read of 0x012345; controller VALID low must reach only the CPU.
    p_acc[1] = 1'b0; p_rw[1] = 1'b1; p_uds[1] = 1'b0; p_lds[1] = 1'b0; p_a[1] = 23'h012345;
    step(2);
    p_valid = 1'b0; step(2);
    p_valid = 1'b1; p_acc[1] = 1'b1; step(5);

    // Simultaneous requests: CPU first, then DMA after the gap.
    p_acc[1] = 1'b0; p_acc[2] = 1'b0; p_a[2] = 23'h7abcde; p_rw[2] = 1'b0;
    step(5);
    p_acc[1] = 1'b1; step(7);
    p_acc[2] = 1'b1; step(5);

    // Both re-request continuously; each owner drops after two owned cycles.
    p_acc[1] = 1'b0; p_acc[2] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      p_acc[1] = !(owner == 1 && t - own_start >= 2);
      p_acc[2] = !(owner == 2 && t - own_start >= 2);
      step(1);
    end
    p_acc[1] = 1'b1; p_acc[2] = 1'b1; step(5);

    // DMA write owns; CPU requests mid-cycle; WTERM must only reach the DMA.
    p_acc[2] = 1'b0; p_rw[2] = 1'b0; step(2);
    p_acc[1] = 1'b0; step(3);
    p_wterm = 1'b0; step(1);
    p_wterm = 1'b1; p_acc[2] = 1'b1; step(6);
    p_acc[1] = 1'b1; step(5);

    // Stalled DMA with CPU pending: watchdog build reclaims and blocks the DMA.
    p_acc[2] = 1'b0; step(10);
    p_acc[1] = 1'b0; step(260);
    p_acc[1] = 1'b1; step(10);
    p_acc[2] = 1'b1; step(2);
    p_acc[2] = 1'b0; step(6);
    p_acc[2] = 1'b1; step(5);

    // Reset in the middle of a DMA cycle, released with both requesting.
    p_acc[2] = 1'b0; step(3);
    p_rst = 1'b1; step(1);
    p_acc[1] = 1'b0; step(1);
    p_rst = 1'b0; step(4);
    p_acc[1] = 1'b1; p_acc[2] = 1'b1; step(6);

    // Random requester traffic with occasional stalls and resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int x = 1; x <= 2; x++) begin
        if (!act[x]) begin
          rand_fields(x);
          if ($urandom_range(3) == 0) begin
            act[x] = 1'b1;
            hold_len[x] = ($urandom_range(40) == 0) ? 300 : int'($urandom_range(6));
          end
        end else if (owner == x) begin
          if (t - own_start > hold_len[x]) act[x] = 1'b0;
        end else if ($urandom_range(199) == 0) begin
          act[x] = 1'b0;
        end
        p_acc[x] = !act[x];
      end
      p_valid = 1'($urandom_range(1));
      p_wterm = 1'($urandom_range(1));
      p_rst   = ($urandom_range(999) == 0);
      step(1);
    end
    p_rst = 1'b0; p_acc[1] = 1'b1; p_acc[2] = 1'b1;
    step(5);
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
